// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 burst responder backed by a word-addressed register array.
// Independent read and write FSMs, one outstanding burst each; every burst increments.
module axi_sram_slave #(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);
   localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_BURST = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;

   logic [31:0]          r_mem [0:(1<<ADDR_BITS)-1];
   logic [1:0]           r_rstate, r_wstate;
   logic [ADDR_BITS-1:0] r_ridx, r_widx;
   logic [4:0]           r_rleft, r_wleft;
   logic [3:0]           r_rcnt, r_rid, r_bid;
   logic [31:0]          r_rdata;
   logic                 r_err;
   logic [ADDR_BITS-1:0] w_aridx, w_awidx, w_ridx_nxt;
   logic                 w_we, w_unused;

   assign w_aridx    = araddr[ADDR_BITS+1:2];
   assign w_awidx    = awaddr[ADDR_BITS+1:2];
   assign w_ridx_nxt = r_ridx + ADDR_BITS'(1);
   assign w_we       = (r_wstate == W_DATA) & wvalid;
   assign w_unused   = &{1'b0, araddr[31:ADDR_BITS+2], araddr[1:0], awaddr[31:ADDR_BITS+2],
                         awaddr[1:0], arsize, arburst, awsize, awburst, wid};

   assign arready = r_rstate == R_IDLE;
   assign rvalid  = r_rstate == R_BURST;
   assign rlast   = rvalid & (r_rleft == 5'd1);
   assign rid     = r_rid;
   assign rdata   = r_rdata;
   assign rresp   = 2'b00;
   assign awready = r_wstate == W_IDLE;
   assign wready  = r_wstate == W_DATA;
   assign bvalid  = r_wstate == W_RESP;
   assign bid     = r_bid;
   assign bresp   = r_err ? 2'b10 : 2'b00;

   // rdata samples r_mem before this edge's write lands, so a colliding beat reads the old word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_ridx   <= '0;
         r_rleft  <= '0;
         r_rcnt   <= '0;
         r_rid    <= '0;
         r_rdata  <= '0;
      end else if (r_rstate == R_IDLE) begin
         if (arvalid) begin
            r_rid   <= arid;
            r_ridx  <= w_aridx;
            r_rleft <= {1'b0, arlen} + 5'd1;
            r_rcnt  <= 4'(READ_LAT > 1 ? READ_LAT - 2 : 0);
            if (READ_LAT == 1) begin
               r_rdata  <= r_mem[w_aridx];
               r_rstate <= R_BURST;
            end else begin
               r_rstate <= R_WAIT;
            end
         end
      end else if (r_rstate == R_WAIT) begin
         r_rcnt <= r_rcnt - 4'd1;
         if (r_rcnt == 4'd0) begin
            r_rdata  <= r_mem[r_ridx];
            r_rstate <= R_BURST;
         end
      end else if (rready) begin
         r_rleft <= r_rleft - 5'd1;
         r_ridx  <= w_ridx_nxt;
         if (r_rleft == 5'd1) r_rstate <= R_IDLE;
         else r_rdata <= r_mem[w_ridx_nxt];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate <= W_IDLE;
         r_widx   <= '0;
         r_wleft  <= '0;
         r_bid    <= '0;
         r_err    <= 1'b0;
      end else if (r_wstate == W_IDLE) begin
         if (awvalid) begin
            r_bid    <= awid;
            r_widx   <= w_awidx;
            r_wleft  <= {1'b0, awlen} + 5'd1;
            r_wstate <= W_DATA;
         end
      end else if (r_wstate == W_DATA) begin
         if (wvalid) begin
            r_widx  <= r_widx + ADDR_BITS'(1);
            r_wleft <= r_wleft - 5'd1;
            if (wlast != (r_wleft == 5'd1)) r_err <= 1'b1;
            if (r_wleft == 5'd1) r_wstate <= W_RESP;
         end
      end else if (bready) begin
         r_wstate <= W_IDLE;
         r_err    <= 1'b0;
      end
   end

   // storage is deliberately outside the reset domain so committed writes survive rst
   always_ff @(posedge clk) begin
      if (w_we)
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) r_mem[r_widx][8*i +: 8] <= wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: drives two responders (READ_LAT 1 and 3) with one shared stream and
// checks them against a flat memory model, a directed vector table and random bursts.
module tb_axi_sram_slave;
   typedef struct {
      bit          wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [31:0] d0;
      logic [3:0]  strb;
      int          bad;
      int          mode;
      logic [1:0]  bresp;
      logic [31:0] ef;
      logic [31:0] el;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [3:0]  arid, arlen, awid, awlen, wid, wstrb;
   logic [31:0] araddr, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst;
   logic        arvalid, rready, awvalid, wlast, wvalid, bready;
   logic [1:0]  arready_o, rlast_o, rvalid_o, awready_o, wready_o, bvalid_o;
   logic [1:0][3:0]  rid_o, bid_o;
   logic [1:0][31:0] rdata_o;
   logic [1:0][1:0]  rresp_o, bresp_o;
   int checks = 0;
   int errors = 0;
   logic [31:0] mm [1024];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rfirst [2];
   logic [31:0] rlastd [2];
   int lat [2] = '{1, 3};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_sram_slave #(.ADDR_BITS(10), .READ_LAT(2*g+1)) u_dut (
         .clk(clk), .rst(rst),
         .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
         .arvalid(arvalid), .arready(arready_o[g]),
         .rid(rid_o[g]), .rdata(rdata_o[g]), .rresp(rresp_o[g]), .rlast(rlast_o[g]),
         .rvalid(rvalid_o[g]), .rready(rready),
         .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
         .awvalid(awvalid), .awready(awready_o[g]),
         .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
         .wready(wready_o[g]),
         .bid(bid_o[g]), .bresp(bresp_o[g]), .bvalid(bvalid_o[g]), .bready(bready)
      );
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [31:0] bmask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int bad, input int bdly, output logic [1:0] resp);
      int t, base, k;
      bit err;
      base = int'(addr[11:2]);
      err = 1'b0;
      resp = 2'b00;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1; wid = id;
      t = 0;
      while (awready_o != 2'b11 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("aw_accept", 32'(t < 50), 32'd1);
      @(negedge clk);
      awvalid = 1'b0;
      t = 0;
      for (int b = 0; b <= int'(len); b++) begin
         wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b];
         wlast = (b == bad) ? (b != int'(len)) : (b == int'(len));
         while (wready_o != 2'b11 && t < 50) begin
            @(negedge clk);
            t++;
         end
         k = (base + b) % 1024;
         mm[k] = (mm[k] & ~bmask(ws[b])) | (wd[b] & bmask(ws[b]));
         err = err | (wlast != (b == int'(len)));
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("w_ready_gap", 32'(t), 32'd0);
      for (int d = 0; d <= bdly; d++) begin
         bready = (d == bdly);
         chk("b_valid", 32'(bvalid_o), 32'd3);
         chk("b_id0", 32'(bid_o[0]), 32'(id));
         chk("b_id1", 32'(bid_o[1]), 32'(id));
         chk("b_resp0", 32'(bresp_o[0]), err ? 32'd2 : 32'd0);
         chk("b_resp1", 32'(bresp_o[1]), err ? 32'd2 : 32'd0);
         resp = bresp_o[0];
         @(negedge clk);
      end
      bready = 1'b0;
      chk("b_done", 32'({bvalid_o, awready_o}), 32'b0011);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int mode);
      int c, t, base;
      int nb [2];
      bit seen [2];
      bit pend [2];
      bit stall [2];
      logic [31:0] pd [2];
      logic pl [2];
      logic [3:0] pat;
      pat = 4'b1001;
      base = int'(addr[11:2]);
      nb = '{0, 0}; seen = '{0, 0}; pend = '{0, 0}; stall = '{0, 0};
      pd = '{0, 0}; pl = '{0, 0};
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      t = 0;
      while (arready_o != 2'b11 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ar_accept", 32'(t < 50), 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      c = 1;
      while ((nb[0] <= int'(len) || nb[1] <= int'(len) || pend[0] || pend[1]) && c < 300) begin
         rready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[(c - 1) % 4] : 1'($urandom_range(0, 1));
         for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
               chk("r_idle_after", 32'({arready_o[i], rvalid_o[i]}), 32'b10);
               pend[i] = 1'b0;
            end else if (nb[i] <= int'(len)) begin
               if (stall[i]) begin
                  chk("r_stall_hold", 32'({rvalid_o[i], rlast_o[i]}), 32'({1'b1, pl[i]}));
                  chk("r_stall_data", rdata_o[i], pd[i]);
               end else if (!seen[i] && (rvalid_o[i] || c == lat[i])) begin
                  chk("r_latency", 32'(2 * c + int'(rvalid_o[i])), 32'(2 * lat[i] + 1));
                  seen[i] = 1'b1;
               end
               if (rvalid_o[i] && rready) begin
                  chk("r_data", rdata_o[i], mm[(base + nb[i]) % 1024]);
                  chk("r_last", 32'(rlast_o[i]), 32'(nb[i] == int'(len)));
                  chk("r_id", 32'(rid_o[i]), 32'(id));
                  chk("r_resp", 32'(rresp_o[i]), 32'd0);
                  if (nb[i] == 0) rfirst[i] = rdata_o[i];
                  rlastd[i] = rdata_o[i];
                  nb[i]++;
                  pend[i] = nb[i] > int'(len);
               end
               stall[i] = rvalid_o[i] && !rready;
               pd[i] = rdata_o[i];
               pl[i] = rlast_o[i];
            end
         end
         @(negedge clk);
         c++;
      end
      chk("r_done", 32'(c < 300), 32'd1);
      rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v [13];
      logic [1:0] resp;
      logic [3:0] len;
      logic [31:0] addr;
      rst = 1'b1;
      arid = '0; arlen = '0; awid = '0; awlen = '0; wid = '0; wstrb = '0;
      araddr = '0; awaddr = '0; wdata = '0;
      arsize = 3'd2; awsize = 3'd2; arburst = 2'b10; awburst = 2'b10;
      arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      //       wr    id     addr        len    d0            strb  bad mode bresp  first         last
      v[0]  = '{1'b1, 4'd5, 32'h040, 4'd3, 32'h11111111, 4'hF, -1, 0, 2'b00, 32'h0,        32'h0};
      v[1]  = '{1'b0, 4'd1, 32'h040, 4'd3, 32'h0,        4'h0, -1, 0, 2'b00, 32'h11111111, 32'h44444444};
      v[2]  = '{1'b1, 4'd2, 32'h080, 4'd0, 32'hAABBCCDD, 4'hF, -1, 0, 2'b00, 32'h0,        32'h0};
      v[3]  = '{1'b1, 4'd3, 32'h080, 4'd0, 32'h000000EE, 4'h1, -1, 0, 2'b00, 32'h0,        32'h0};
      v[4]  = '{1'b0, 4'd4, 32'h080, 4'd0, 32'h0,        4'h0, -1, 0, 2'b00, 32'hAABBCCEE, 32'hAABBCCEE};
      v[5]  = '{1'b1, 4'd9, 32'h080, 4'd0, 32'hFFFFFFFF, 4'h0, -1, 0, 2'b00, 32'h0,        32'h0};
      v[6]  = '{1'b0, 4'hA, 32'h080, 4'd0, 32'h0,        4'h0, -1, 0, 2'b00, 32'hAABBCCEE, 32'hAABBCCEE};
      v[7]  = '{1'b0, 4'd6, 32'h040, 4'd3, 32'h0,        4'h0, -1, 1, 2'b00, 32'h11111111, 32'h44444444};
      v[8]  = '{1'b1, 4'd7, 32'h100, 4'd1, 32'h12345678, 4'hF,  0, 0, 2'b10, 32'h0,        32'h0};
      v[9]  = '{1'b1, 4'd8, 32'h100, 4'd1, 32'h12345678, 4'hF, -1, 0, 2'b00, 32'h0,        32'h0};
      v[10] = '{1'b1, 4'hC, 32'hFFC, 4'd1, 32'hCAFEF00D, 4'hF, -1, 0, 2'b00, 32'h0,        32'h0};
      v[11] = '{1'b0, 4'hB, 32'hFFC, 4'd1, 32'h0,        4'h0, -1, 0, 2'b00, 32'hCAFEF00D, 32'hDC10011E};
      v[12] = '{1'b0, 4'hD, 32'h104, 4'd0, 32'h0,        4'h0, -1, 2, 2'b00, 32'h23456789, 32'h23456789};
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", 32'({arready_o[i], awready_o[i]}), 32'b11);
         chk("rst_valid", 32'({rvalid_o[i], wready_o[i], bvalid_o[i], rlast_o[i]}), 32'd0);
         chk("rst_rdata", rdata_o[i], 32'd0);
         chk("rst_ids", 32'({rid_o[i], bid_o[i], rresp_o[i], bresp_o[i]}), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int f = 0; f < 64; f++) begin
         for (int b = 0; b < 16; b++) begin
            wd[b] = $urandom;
            ws[b] = 4'hF;
         end
         do_write(4'(f), 32'(f * 64), 4'hF, -1, 0, resp);
      end
      for (int n = 0; n < 13; n++) begin
         if (v[n].wr) begin
            for (int b = 0; b < 16; b++) begin
               wd[b] = v[n].d0 + 32'(b) * 32'h11111111;
               ws[b] = v[n].strb;
            end
            do_write(v[n].id, v[n].addr, v[n].len, v[n].bad, 0, resp);
            chk("vec_bresp", 32'(resp), 32'(v[n].bresp));
         end else begin
            do_read(v[n].id, v[n].addr, v[n].len, v[n].mode);
            for (int i = 0; i < 2; i++) begin
               chk("vec_rfirst", rfirst[i], v[n].ef);
               chk("vec_rlast", rlastd[i], v[n].el);
            end
         end
      end
      arid = 4'h3; araddr = 32'h0; arlen = 4'hF; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rready = 1'b1;
      repeat (3) @(negedge clk);
      chk("pre_rst_rvalid", 32'(rvalid_o), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_r", 32'({rvalid_o, rlast_o, arready_o}), 32'b000011);
      @(negedge clk);
      rst = 1'b0;
      rready = 1'b0;
      do_read(4'h9, 32'h40, 4'd3, 0);
      for (int i = 0; i < 2; i++) chk("post_rst_first", rfirst[i], 32'h11111111);
      for (int n = 0; n < 60; n++) begin
         len = 4'($urandom_range(0, 15));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            for (int b = 0; b < 16; b++) begin
               wd[b] = $urandom;
               ws[b] = 4'($urandom);
            end
            do_write(4'($urandom), addr, len,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1,
                     int'($urandom_range(0, 2)), resp);
         end else begin
            do_read(4'($urandom), addr, len, ($urandom_range(0, 2) == 0) ? 0 : 2);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
